// File: rtl/launchpad_pkg.sv
// Shared launchpad definitions: key indices, octave limits and scanner FSM states.
// The tone converter imports the same constants.
package launchpad_pkg;

  localparam int         KEY_W        = 5;
  localparam int         NUM_NOTES    = 12;
  localparam logic [4:0] KEY_OCT_DN   = 5'd12;
  localparam logic [4:0] KEY_OCT_UP   = 5'd13;
  localparam logic [4:0] KEY_NONE     = 5'd16;
  localparam logic [2:0] OCTAVE_RESET = 3'd4;
  localparam logic [2:0] OCTAVE_MAX   = 3'd7;

  typedef enum logic [1:0] {ST_IDLE, ST_NOTE, ST_OCT} scan_state_e;
  typedef enum logic [1:0] {KC_NONE, KC_NOTE, KC_OCT_DN, KC_OCT_UP} key_class_e;

  // Keys 14 and 15 are unassigned and behave exactly like no key.
  function automatic key_class_e classify(input logic [KEY_W-1:0] key);
    key_class_e cls;
    if (key < KEY_W'(NUM_NOTES))   cls = KC_NOTE;
    else if (key == KEY_OCT_DN)    cls = KC_OCT_DN;
    else if (key == KEY_OCT_UP)    cls = KC_OCT_UP;
    else                           cls = KC_NONE;
    return cls;
  endfunction

  function automatic logic [KEY_W-1:0] row_lowest(input logic [1:0] row, input logic [3:0] col);
    logic [KEY_W-1:0] k;
    k = KEY_NONE;
    for (int c = 3; c >= 0; c--) begin
      if (col[c]) k = {1'b0, row, 2'(c)};
    end
    return k;
  endfunction

  function automatic logic [2:0] oct_step(input logic [2:0] oct, input logic up);
    logic [2:0] r;
    if (up) r = (oct == OCTAVE_MAX) ? oct : oct + 3'd1;
    else    r = (oct == 3'd0)       ? oct : oct - 3'd1;
    return r;
  endfunction

endpackage

// File: rtl/key_debouncer.sv
// Frame-rate debouncer: a candidate is accepted once it has been seen in
// DEBOUNCE_FRAMES consecutive frames; accept_o pulses in that frame-end cycle.
module key_debouncer
  import launchpad_pkg::*;
#(
  parameter int DEBOUNCE_FRAMES = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             frame_end_i,
  input  logic [KEY_W-1:0] cand_i,
  output logic [KEY_W-1:0] key_o,
  output logic             accept_o
);

  localparam int               CNT_W   = $clog2(DEBOUNCE_FRAMES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_FRAMES);

  logic [KEY_W-1:0] prev_q, prev_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             same;

  assign same = (cand_i == prev_q);

  always_comb begin
    prev_d = prev_q;
    cnt_d  = cnt_q;
    if (frame_end_i) begin
      if (same) begin
        if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
      end else begin
        prev_d = cand_i;
        cnt_d  = CNT_W'(1);
      end
    end
  end

  // A restart that lands directly on the threshold (DEBOUNCE_FRAMES=1) is a new key.
  assign accept_o = frame_end_i && (cnt_d == CNT_MAX) && (!same || cnt_q != CNT_MAX);
  assign key_o    = cand_i;

  always_ff @(posedge CLK) begin
    if (RST) begin
      prev_q <= KEY_NONE;
      cnt_q  <= '0;
    end else begin
      prev_q <= prev_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/keypad_note_scanner.sv
// 4x4 launchpad scanner: row scan, per-frame lowest-key candidate, debounce,
// and the note/octave FSM driving the piano player (Bin, EN, octave).
module keypad_note_scanner
  import launchpad_pkg::*;
#(
  parameter int SCAN_DIV        = 50000,
  parameter int DEBOUNCE_FRAMES = 4
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [3:0] COL,
  output logic [3:0] ROW,
  output logic [3:0] Bin,
  output logic       EN,
  output logic [2:0] octave
);

  localparam int               DIV_W   = $clog2(SCAN_DIV);
  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(SCAN_DIV - 1);

  logic [DIV_W-1:0] div_q, div_d;
  logic [1:0]       row_q, row_d;
  logic [KEY_W-1:0] cand_q, cand_d;
  logic             tick, frame_end;
  logic [KEY_W-1:0] row_key, merged;

  assign tick      = (div_q == DIV_MAX);
  assign frame_end = tick && (row_q == 2'd3);
  assign row_key   = row_lowest(row_q, COL);
  assign merged    = (row_key < cand_q) ? row_key : cand_q;

  always_comb begin
    div_d  = tick ? '0 : div_q + 1'b1;
    row_d  = row_q;
    cand_d = cand_q;
    if (tick) begin
      row_d  = row_q + 2'd1;
      cand_d = frame_end ? KEY_NONE : merged;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      div_q  <= '0;
      row_q  <= '0;
      cand_q <= KEY_NONE;
    end else begin
      div_q  <= div_d;
      row_q  <= row_d;
      cand_q <= cand_d;
    end
  end

  assign ROW = 4'b0001 << row_q;

  // The row-3 sample is folded in combinationally so the frame's candidate is
  // judged in the frame-end cycle itself.
  logic [KEY_W-1:0] acc_key;
  logic             accept;

  key_debouncer #(.DEBOUNCE_FRAMES(DEBOUNCE_FRAMES)) u_deb (
    .CLK        (CLK),
    .RST        (RST),
    .frame_end_i(frame_end),
    .cand_i     (merged),
    .key_o      (acc_key),
    .accept_o   (accept)
  );

  scan_state_e state_q, state_d;
  logic [3:0]  bin_q, bin_d;
  logic        en_q, en_d;
  logic [2:0]  oct_q, oct_d;
  key_class_e  cls;

  assign cls = classify(acc_key);

  always_comb begin
    state_d = state_q;
    bin_d   = bin_q;
    en_d    = en_q;
    oct_d   = oct_q;
    if (accept) begin
      unique case (state_q)
        ST_NOTE: begin
          unique case (cls)
            KC_NOTE:   bin_d = acc_key[3:0];
            KC_OCT_DN,
            KC_OCT_UP: begin
              en_d    = 1'b0;
              oct_d   = oct_step(oct_q, cls == KC_OCT_UP);
              state_d = ST_OCT;
            end
            default: begin
              en_d    = 1'b0;
              state_d = ST_IDLE;
            end
          endcase
        end
        ST_IDLE, ST_OCT: begin
          unique case (cls)
            KC_NOTE: begin
              bin_d   = acc_key[3:0];
              en_d    = 1'b1;
              state_d = ST_NOTE;
            end
            // An octave key only steps once per press; from OCT it is still held.
            KC_OCT_DN,
            KC_OCT_UP: begin
              if (state_q == ST_IDLE) begin
                oct_d   = oct_step(oct_q, cls == KC_OCT_UP);
                state_d = ST_OCT;
              end
            end
            default: state_d = ST_IDLE;
          endcase
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ST_IDLE;
      bin_q   <= '0;
      en_q    <= 1'b0;
      oct_q   <= OCTAVE_RESET;
    end else begin
      state_q <= state_d;
      bin_q   <= bin_d;
      en_q    <= en_d;
      oct_q   <= oct_d;
    end
  end

  assign Bin    = bin_q;
  assign EN     = en_q;
  assign octave = oct_q;

endmodule

// File: tb/tb_keypad_note_scanner.sv
// Bench for keypad_note_scanner: directed scenarios plus random key traffic,
// all outputs compared every clock against a frame-level behavioural model.
module tb_keypad_note_scanner;

  localparam int SD    = 4;
  localparam int DF    = 3;
  localparam int FRAME = 4 * SD;

  logic        CLK = 1'b0;
  logic        RST;
  logic [3:0]  COL, ROW, Bin;
  logic        EN;
  logic [2:0]  octave;
  logic [15:0] keys;

  int checks = 0;
  int errs   = 0;

  always #5 CLK = ~CLK;

  // Key matrix: a pressed key shorts its column to the driven row.
  always_comb begin
    COL = 4'b0000;
    for (int r = 0; r < 4; r++)
      COL = COL | (ROW[r] ? keys[r*4 +: 4] : 4'b0000);
  end

  keypad_note_scanner #(.SCAN_DIV(SD), .DEBOUNCE_FRAMES(DF)) dut (
    .CLK   (CLK),
    .RST   (RST),
    .COL   (COL),
    .ROW   (ROW),
    .Bin   (Bin),
    .EN    (EN),
    .octave(octave)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference model: cycle counter since reset gives the scan phase; each frame
  // yields the lowest held key; the last frames decide acceptance.
  int m_cyc, m_seen, m_mode, m_bin, m_en, m_oct;
  int m_frames[$];

  task automatic m_apply(input int key);
    int k;
    k = (key == 14 || key == 15) ? 16 : key;
    if (m_mode == 1) begin
      if (k < 12) m_bin = k;
      else if (k == 12 || k == 13) begin
        m_en = 0; m_mode = 2;
        if (k == 13 && m_oct < 7) m_oct++;
        if (k == 12 && m_oct > 0) m_oct--;
      end else begin
        m_en = 0; m_mode = 0;
      end
    end else begin
      if (k < 12) begin
        m_bin = k; m_en = 1; m_mode = 1;
      end else if (k == 12 || k == 13) begin
        if (m_mode == 0) begin
          m_mode = 2;
          if (k == 13 && m_oct < 7) m_oct++;
          if (k == 12 && m_oct > 0) m_oct--;
        end
      end else m_mode = 0;
    end
  endtask

  task automatic m_frame(input int c);
    int  n;
    bit  stable;
    m_frames.push_back(c);
    if (m_frames.size() > DF + 1) void'(m_frames.pop_front());
    n = m_frames.size();
    stable = (n >= DF);
    if (stable)
      for (int i = 0; i < DF; i++)
        if (m_frames[n-1-i] != c) stable = 0;
    if (stable && (n == DF || m_frames[n-1-DF] != c)) m_apply(c);
  endtask

  task automatic m_edge();
    int r, k;
    if (RST) begin
      m_cyc = 0; m_seen = 16; m_mode = 0;
      m_bin = 0; m_en = 0; m_oct = 4;
      m_frames.delete();
    end else begin
      if (m_cyc % SD == SD - 1) begin
        r = (m_cyc / SD) % 4;
        for (int c = 0; c < 4; c++) begin
          k = r * 4 + c;
          if (keys[k] && k < m_seen) m_seen = k;
        end
        if (r == 3) begin
          m_frame(m_seen);
          m_seen = 16;
        end
      end
      m_cyc++;
    end
  endtask

  task automatic step();
    @(posedge CLK);
    m_edge();
    #1;
    chk("row", ROW, 1 << ((m_cyc / SD) % 4));
    chk("bin", Bin, m_bin);
    chk("en", EN, m_en);
    chk("oct", octave, m_oct);
  endtask

  task automatic run_to(input int n);
    for (int g = 0; g < 4 * FRAME && m_cyc < n; g++) step();
  endtask

  task automatic align();
    for (int g = 0; g < FRAME && m_cyc % FRAME != 0; g++) step();
  endtask

  task automatic frames(input int n);
    repeat (n * FRAME) step();
  endtask

  initial begin
    int kind, len;
    RST  = 1'b1;
    keys = 16'h0000;
    m_cyc = 0; m_seen = 16; m_mode = 0; m_bin = 0; m_en = 0; m_oct = 4;

    // Reset values
    keys = 16'h0001 << 5;
    repeat (5) step();
    chk("rst_row", ROW, 1);
    chk("rst_bin", Bin, 0);
    chk("rst_en", EN, 0);
    chk("rst_oct", octave, 4);

    // Single press of key 5 from reset release
    RST = 1'b0;
    run_to(3);
    chk("row0_hold", ROW, 4'b0001);
    step();
    chk("row1_step", ROW, 4'b0010);
    run_to(47);
    chk("press_en_early", EN, 0);
    step();
    chk("press_en", EN, 1);
    chk("press_bin", Bin, 5);
    keys = 16'h0000;
    run_to(95);
    chk("release_en_early", EN, 1);
    step();
    chk("release_en", EN, 0);
    chk("release_bin", Bin, 5);

    // Bounce on key 7: toggles every frame, then held
    align();
    for (int f = 0; f < 6; f++) begin
      keys = (f % 2 == 0) ? (16'h0001 << 7) : 16'h0000;
      frames(1);
      chk("bounce_en", EN, 0);
    end
    keys = 16'h0001 << 7;
    repeat (3 * FRAME - 1) step();
    chk("bounce_wait", EN, 0);
    step();
    chk("bounce_en_on", EN, 1);
    chk("bounce_bin", Bin, 7);

    // Priority and note change without an EN gap
    keys = 16'h0000;
    frames(4);
    keys = (16'h0001 << 9) | (16'h0001 << 2);
    frames(3);
    chk("prio_bin", Bin, 2);
    chk("prio_en", EN, 1);
    keys = 16'h0001 << 9;
    for (int i = 0; i < 3 * FRAME; i++) begin
      step();
      chk("change_no_gap", EN, 1);
    end
    chk("change_bin", Bin, 9);

    // Octave stepping and saturation
    keys = 16'h0000;
    frames(4);
    chk("note_off", EN, 0);
    keys = 16'h0001 << 13;
    frames(10);
    chk("oct_single", octave, 5);
    keys = 16'h0000;
    frames(4);
    repeat (3) begin
      keys = 16'h0001 << 13; frames(4);
      keys = 16'h0000;       frames(4);
    end
    chk("oct_sat_hi", octave, 7);
    repeat (8) begin
      keys = 16'h0001 << 12; frames(4);
      keys = 16'h0000;       frames(4);
    end
    chk("oct_sat_lo", octave, 0);

    // Reset mid-press
    align();
    keys = 16'h0001 << 3;
    frames(4);
    chk("k3_en", EN, 1);
    chk("k3_bin", Bin, 3);
    RST = 1'b1;
    step();
    chk("midrst_en", EN, 0);
    chk("midrst_bin", Bin, 0);
    chk("midrst_oct", octave, 4);
    chk("midrst_row", ROW, 1);
    RST = 1'b0;
    run_to(47);
    chk("reacc_early", EN, 0);
    step();
    chk("reacc_en", EN, 1);
    chk("reacc_bin", Bin, 3);

    // Random traffic, including short bounces and occasional resets
    for (int s = 0; s < 150; s++) begin
      if ($urandom_range(0, 99) < 4) begin
        RST = 1'b1;
        repeat ($urandom_range(1, 3)) step();
        RST = 1'b0;
      end
      kind = $urandom_range(0, 3);
      case (kind)
        0:       keys = 16'h0000;
        1, 2:    keys = 16'h0001 << $urandom_range(0, 15);
        default: keys = (16'h0001 << $urandom_range(0, 15)) | (16'h0001 << $urandom_range(0, 15));
      endcase
      len = $urandom_range(3, 6 * FRAME);
      repeat (len) step();
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/keypad_note_scanner.md
# keypad_note_scanner

Front-end stage of the piano path. Scans the 4x4 launchpad key matrix, debounces key presses, and encodes them into the note code, enable and octave that the piano player stage consumes (`Bin`, `EN`, `octave`). Twelve keys map to the chromatic notes. Two keys step the octave down or up.

## Interface

**Parameters**
- `SCAN_DIV`, default 50000: clocks per row slot; one scan frame is 4*`SCAN_DIV` clocks; minimum 2.
- `DEBOUNCE_FRAMES`, default 4: number of consecutive identical frames required to accept a key state; minimum 1.

**Ports**
- `CLK` in 1: system clock; the only clock.
- `RST` in 1: synchronous, active-high reset.
- `COL` in 4: column sense lines; active-high; bit c is 1 when key (row*4+c) is pressed on the driven row.
- `ROW` out 4: one-hot, active-high row drive.
- `Bin` out 4: note code 0..11 for the piano player stage.
- `EN` out 1: high while an accepted note key is held.
- `octave` out 3: current octave, 0..7.

## Operation

**Reset values**
- `ROW`=4'b0001, `Bin`=0, `EN`=0, `octave`=3'd4.
- Divider, row index, candidate key, previous candidate and stable count all cleared.
- `RST` asserted mid-frame or mid-press aborts everything and returns to these values on the next edge.

**Scan**
- Divider counts 0..`SCAN_DIV`-1. A tick occurs when the divider equals `SCAN_DIV`-1.
- On a tick, `COL` is sampled for the current row and the row index advances (3 wraps to 0). `ROW` is the one-hot of the row index.
- The tick on row 3 is the frame end.

**Frame candidate**
- Candidate = lowest key index with its `COL` bit seen high during the frame; 16 (NONE) if no key was seen.
- Multiple keys pressed: the lowest index wins.

**Debounce**
- At each frame end:
  - If candidate == previous candidate, stable count increments, saturating at `DEBOUNCE_FRAMES`.
  - Otherwise stable count = 1 and previous candidate = candidate.
- When stable count first reaches `DEBOUNCE_FRAMES`, the candidate becomes the accepted key.

**Key map**
- 0..11: notes; `Bin` = key index.
- 12: octave down.
- 13: octave up.
- 14, 15: ignored, treated as NONE.

**FSM: IDLE, NOTE, OCT**
- **IDLE**
  - Accept a note key: `Bin`=key, `EN`=1, go to NOTE.
  - Accept 12 or 13: adjust `octave` once, go to OCT.
- **NOTE**
  - Accept a different note key: update `Bin`; `EN` stays 1.
  - Accept NONE: `EN`=0, go to IDLE; `Bin` keeps its last value.
  - Accept an octave key: `EN`=0, adjust `octave` once, go to OCT.
- **OCT**
  - No repeat while the octave key is held.
  - Accept NONE: go to IDLE.
  - Accept a note key: behave as in IDLE.
- `octave` saturates: down at 0 stays 0; up at 7 stays 7.

## Timing

- Outputs are registered and update on the edge after the frame-end tick that completes debounce.
- Key stable from `RST` deassertion:
  - Frame k ends at clock 4k*`SCAN_DIV`-1 after reset release.
  - Outputs change at clock 4*`DEBOUNCE_FRAMES`*`SCAN_DIV`.
- Release latency has the same bound as press latency: `DEBOUNCE_FRAMES` frames plus 1 clock.
- A bounce shorter than one frame never reaches the outputs once the count is restarted.
- No backpressure: the downstream player samples `Bin`/`EN`/`octave` every clock.

## Structure

- **Shared package `launchpad_pkg`:**
  - Key index constants `KEY_OCT_DN`=12, `KEY_OCT_UP`=13, `KEY_NONE`=16.
  - `OCTAVE_RESET`=4, `OCTAVE_MAX`=7.
  - FSM state enum.
  - These constants are reused by the tone converter.
- **Sub-module `key_debouncer`:**
  - Parameter `DEBOUNCE_FRAMES`.
  - Inputs: `CLK`, `RST`, frame_end, 5-bit candidate.
  - Outputs: accepted key, 1-cycle accept pulse.
- The top level holds the divider, row scan and FSM.

## Test plan

Use `SCAN_DIV`=4 and `DEBOUNCE_FRAMES`=3 throughout.

1. **Reset:** hold `RST` 5 clocks. Expect `ROW`=0001, `Bin`=0, `EN`=0, `octave`=4. `ROW` steps 0001→0010 after 4 clocks.
2. **Single press:** hold key 5 (row 1, col 1) from reset release. Expect `EN`=0 through clock 47, then `EN`=1 and `Bin`=5 at clock 48. Release it: `EN`=0 three frames later, `Bin` still 5.
3. **Bounce:** toggle key 7 each frame for 6 frames, then hold it. Expect no `EN` until 3 stable frames, then `Bin`=7.
4. **Priority and change:** press keys 9 and 2 together → `Bin`=2. Release 2 while 9 stays held → `Bin`=9 with `EN` held at 1 with no gap.
5. **Octave:** hold key 13 for 10 frames → `octave`=5 (single step). Press key 13 again 3 more times → saturates at 7. Press key 12 eight times → saturates at 0.
6. **Reset mid-press:** key 3 accepted (`EN`=1), assert `RST` for 1 clock. Expect `EN`=0, `Bin`=0, `octave`=4 on the next edge. Re-acceptance comes 3 frames later.
